// File: rtl/board_buffer.sv
// board_buffer
// Ping-pong owner of the two Game-of-Life board banks. The front bank holds
// the current generation and is read by the logic engine (port A) and the
// renderer (port B). The back bank takes the next generation from the logic
// engine (port A). A buf_swap pulse flips the roles. Ready stays low until the
// read pipelines carry data from the new front bank. After reset both banks
// are zeroed before ready is first reported.
//
// Ports
//   clk_in / rst_in            clock, synchronous active-high reset
//   buf_swap_in                one-cycle swap request
//   buf_ready_out              buffers consistent, a swap is accepted
//   swap_err_out               sticky: a swap request was dropped
//   front_sel_out              index of the current front bank
//   logic_rd_addr_in/_data_out logic-engine front read, RD_LAT latency
//   logic_wr_*_in              logic-engine back-bank write
//   render_rd_addr_in/_data_out renderer front read, RD_LAT latency
//   bankN_a_*                  bank N port A (read/write)
//   bankN_b_*                  bank N port B (read-only)
module board_buffer #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              buf_swap_in,
  output logic              buf_ready_out,
  output logic              swap_err_out,
  output logic              front_sel_out,
  input  logic [ADDR_W-1:0] logic_rd_addr_in,
  output logic [DATA_W-1:0] logic_rd_data_out,
  input  logic              logic_wr_en_in,
  input  logic [ADDR_W-1:0] logic_wr_addr_in,
  input  logic [DATA_W-1:0] logic_wr_data_in,
  input  logic [ADDR_W-1:0] render_rd_addr_in,
  output logic [DATA_W-1:0] render_rd_data_out,
  output logic [ADDR_W-1:0] bank0_a_addr_out,
  output logic              bank0_a_we_out,
  output logic [DATA_W-1:0] bank0_a_din_out,
  input  logic [DATA_W-1:0] bank0_a_dout_in,
  output logic [ADDR_W-1:0] bank0_b_addr_out,
  input  logic [DATA_W-1:0] bank0_b_dout_in,
  output logic [ADDR_W-1:0] bank1_a_addr_out,
  output logic              bank1_a_we_out,
  output logic [DATA_W-1:0] bank1_a_din_out,
  input  logic [DATA_W-1:0] bank1_a_dout_in,
  output logic [ADDR_W-1:0] bank1_b_addr_out,
  input  logic [DATA_W-1:0] bank1_b_dout_in
);

  localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_SETTLE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              front_sel_q, front_sel_d;
  logic [RD_LAT-1:0] sel_pipe_q, sel_pipe_d;
  logic              swap_err_q, swap_err_d;
  logic [CNT_W-1:0]  settle_cnt_q, settle_cnt_d;

  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    front_sel_d  = front_sel_q;
    swap_err_d   = swap_err_q;
    settle_cnt_d = settle_cnt_q;

    // Bank select follows each read through the BRAM latency.
    sel_pipe_d[0] = front_sel_q;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      sel_pipe_d[i] = sel_pipe_q[i-1];
    end

    case (state_q)
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == '1) state_d = ST_IDLE;
        if (buf_swap_in) swap_err_d = 1'b1;
      end
      ST_IDLE: begin
        if (buf_swap_in) begin
          front_sel_d  = ~front_sel_q;
          settle_cnt_d = CNT_W'(RD_LAT);
          state_d      = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (buf_swap_in) swap_err_d = 1'b1;
        settle_cnt_d = settle_cnt_q - CNT_W'(1);
        if (settle_cnt_q == CNT_W'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_CLEAR;
      clr_addr_q   <= '0;
      front_sel_q  <= 1'b0;
      sel_pipe_q   <= '0;
      swap_err_q   <= 1'b0;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      front_sel_q  <= front_sel_d;
      sel_pipe_q   <= sel_pipe_d;
      swap_err_q   <= swap_err_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  // Bank port mapping. Writes are masked while reset is held so the state
  // left over from before reset cannot touch either bank in that cycle.
  always_comb begin
    bank0_a_addr_out = logic_rd_addr_in;
    bank0_a_we_out   = 1'b0;
    bank0_a_din_out  = logic_wr_data_in;
    bank1_a_addr_out = logic_rd_addr_in;
    bank1_a_we_out   = 1'b0;
    bank1_a_din_out  = logic_wr_data_in;
    bank0_b_addr_out = render_rd_addr_in;
    bank1_b_addr_out = render_rd_addr_in;

    if (state_q == ST_CLEAR) begin
      bank0_a_addr_out = clr_addr_q;
      bank0_a_we_out   = ~rst_in;
      bank0_a_din_out  = '0;
      bank1_a_addr_out = clr_addr_q;
      bank1_a_we_out   = ~rst_in;
      bank1_a_din_out  = '0;
    end else if (front_sel_q) begin
      bank0_a_addr_out = logic_wr_addr_in;
      bank0_a_we_out   = logic_wr_en_in & ~rst_in;
    end else begin
      bank1_a_addr_out = logic_wr_addr_in;
      bank1_a_we_out   = logic_wr_en_in & ~rst_in;
    end
  end

  // Combinational so ready already drops in the swap-request cycle.
  assign buf_ready_out = (state_q == ST_IDLE) & ~buf_swap_in & ~rst_in;
  assign swap_err_out  = swap_err_q;
  assign front_sel_out = front_sel_q;

  assign logic_rd_data_out  = sel_pipe_q[RD_LAT-1] ? bank1_a_dout_in : bank0_a_dout_in;
  assign render_rd_data_out = sel_pipe_q[RD_LAT-1] ? bank1_b_dout_in : bank0_b_dout_in;

endmodule

// File: tb/tb_board_buffer.sv
// Bench for board_buffer: two behavioural BRAM banks with RD_LAT latency,
// random and directed stimulus, checked against a cycle-count reference model.
module tb_board_buffer;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned DEPTH  = 16;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic              rst_in, buf_swap_in, logic_wr_en_in;
  logic [ADDR_W-1:0] logic_rd_addr_in, logic_wr_addr_in, render_rd_addr_in;
  logic [DATA_W-1:0] logic_wr_data_in;
  logic              buf_ready_out, swap_err_out, front_sel_out;
  logic [DATA_W-1:0] logic_rd_data_out, render_rd_data_out;
  logic [ADDR_W-1:0] bank0_a_addr_out, bank0_b_addr_out, bank1_a_addr_out, bank1_b_addr_out;
  logic              bank0_a_we_out, bank1_a_we_out;
  logic [DATA_W-1:0] bank0_a_din_out, bank1_a_din_out;
  logic [DATA_W-1:0] bank0_a_dout_in, bank0_b_dout_in, bank1_a_dout_in, bank1_b_dout_in;

  board_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .buf_swap_in(buf_swap_in),
    .buf_ready_out(buf_ready_out), .swap_err_out(swap_err_out), .front_sel_out(front_sel_out),
    .logic_rd_addr_in(logic_rd_addr_in), .logic_rd_data_out(logic_rd_data_out),
    .logic_wr_en_in(logic_wr_en_in), .logic_wr_addr_in(logic_wr_addr_in),
    .logic_wr_data_in(logic_wr_data_in),
    .render_rd_addr_in(render_rd_addr_in), .render_rd_data_out(render_rd_data_out),
    .bank0_a_addr_out(bank0_a_addr_out), .bank0_a_we_out(bank0_a_we_out),
    .bank0_a_din_out(bank0_a_din_out), .bank0_a_dout_in(bank0_a_dout_in),
    .bank0_b_addr_out(bank0_b_addr_out), .bank0_b_dout_in(bank0_b_dout_in),
    .bank1_a_addr_out(bank1_a_addr_out), .bank1_a_we_out(bank1_a_we_out),
    .bank1_a_din_out(bank1_a_din_out), .bank1_a_dout_in(bank1_a_dout_in),
    .bank1_b_addr_out(bank1_b_addr_out), .bank1_b_dout_in(bank1_b_dout_in)
  );

  // Behavioural BRAM banks (read-first, RD_LAT-cycle output pipeline).
  // While scramble is set they fill themselves with junk so clearing is visible.
  logic [DATA_W-1:0] mem0 [DEPTH];
  logic [DATA_W-1:0] mem1 [DEPTH];
  logic [DATA_W-1:0] p0a [RD_LAT];
  logic [DATA_W-1:0] p0b [RD_LAT];
  logic [DATA_W-1:0] p1a [RD_LAT];
  logic [DATA_W-1:0] p1b [RD_LAT];
  logic        scramble = 1'b1;
  int unsigned scr_idx  = 0;

  always @(posedge clk_in) begin
    if (scramble) begin
      mem0[scr_idx[ADDR_W-1:0]] <= DATA_W'($urandom);
      mem1[scr_idx[ADDR_W-1:0]] <= DATA_W'($urandom);
      scr_idx <= scr_idx + 1;
    end else begin
      if (bank0_a_we_out) mem0[bank0_a_addr_out] <= bank0_a_din_out;
      if (bank1_a_we_out) mem1[bank1_a_addr_out] <= bank1_a_din_out;
    end
    p0a[0] <= mem0[bank0_a_addr_out];
    p0b[0] <= mem0[bank0_b_addr_out];
    p1a[0] <= mem1[bank1_a_addr_out];
    p1b[0] <= mem1[bank1_b_addr_out];
    for (int i = 1; i < RD_LAT; i++) begin
      p0a[i] <= p0a[i-1];
      p0b[i] <= p0b[i-1];
      p1a[i] <= p1a[i-1];
      p1b[i] <= p1b[i-1];
    end
  end
  assign bank0_a_dout_in = p0a[RD_LAT-1];
  assign bank0_b_dout_in = p0b[RD_LAT-1];
  assign bank1_a_dout_in = p1a[RD_LAT-1];
  assign bank1_b_dout_in = p1b[RD_LAT-1];

  // Reference model: cycles remaining until ready, whether that wait is the
  // post-reset clear, front index, sticky error and the contents of each bank.
  int                m_busy     = DEPTH;
  bit                m_clearing = 1'b1;
  bit                m_front    = 1'b0;
  bit                m_err      = 1'b0;
  bit                chk_zero   = 1'b0;
  logic [DATA_W-1:0] ref_mem [2][DEPTH];
  bit                pv [RD_LAT];
  logic [DATA_W-1:0] pl [RD_LAT];
  logic [DATA_W-1:0] pr [RD_LAT];

  int n_checks = 0;
  int n_errors = 0;
  logic              last_ready, last_err;
  logic [DATA_W-1:0] last_logic, last_render;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: check outputs at the falling edge, advance the model at the
  // rising edge, return 1 time unit later ready for the next input drive.
  task automatic cycle();
    logic [DATA_W-1:0] acc0, acc1;
    @(negedge clk_in);
    last_ready  = buf_ready_out;
    last_err    = swap_err_out;
    last_logic  = logic_rd_data_out;
    last_render = render_rd_data_out;
    check("ready", 32'(buf_ready_out), 32'(!rst_in && m_busy == 0 && !buf_swap_in));
    if (rst_in) begin
      check("we_in_reset", 32'({bank0_a_we_out, bank1_a_we_out}), 32'd0);
    end else begin
      check("front_sel", 32'(front_sel_out), 32'(m_front));
      check("swap_err", 32'(swap_err_out), 32'(m_err));
      if (m_clearing) begin
        check("clr_addr0", 32'(bank0_a_addr_out), 32'(DEPTH - m_busy));
        check("clr_addr1", 32'(bank1_a_addr_out), 32'(DEPTH - m_busy));
        check("clr_we", 32'({bank0_a_we_out, bank1_a_we_out}), 32'd3);
        check("clr_din", 32'(bank0_a_din_out | bank1_a_din_out), 32'd0);
      end else begin
        check("front_we", 32'(m_front ? bank1_a_we_out : bank0_a_we_out), 32'd0);
        check("back_we", 32'(m_front ? bank0_a_we_out : bank1_a_we_out), 32'(logic_wr_en_in));
        if (logic_wr_en_in) begin
          check("back_addr", 32'(m_front ? bank0_a_addr_out : bank1_a_addr_out), 32'(logic_wr_addr_in));
          check("back_din", 32'(m_front ? bank0_a_din_out : bank1_a_din_out), 32'(logic_wr_data_in));
        end
      end
    end
    if (pv[RD_LAT-1]) begin
      check("logic_rd", 32'(logic_rd_data_out), 32'(pl[RD_LAT-1]));
      check("render_rd", 32'(render_rd_data_out), 32'(pr[RD_LAT-1]));
    end
    if (chk_zero) begin
      acc0 = '0;
      acc1 = '0;
      for (int i = 0; i < DEPTH; i++) begin
        acc0 |= mem0[i];
        acc1 |= mem1[i];
      end
      check("bank0_cleared", 32'(acc0), 32'd0);
      check("bank1_cleared", 32'(acc1), 32'd0);
      chk_zero = 1'b0;
    end

    @(posedge clk_in);
    for (int i = RD_LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pl[i] = pl[i-1];
      pr[i] = pr[i-1];
    end
    pv[0] = !rst_in && !m_clearing;
    pl[0] = ref_mem[m_front][logic_rd_addr_in];
    pr[0] = ref_mem[m_front][render_rd_addr_in];
    if (rst_in) begin
      m_busy     = DEPTH;
      m_clearing = 1'b1;
      m_front    = 1'b0;
      m_err      = 1'b0;
      chk_zero   = 1'b0;
      for (int i = 0; i < RD_LAT; i++) pv[i] = 1'b0;
    end else begin
      if (!m_clearing && logic_wr_en_in) ref_mem[!m_front][logic_wr_addr_in] = logic_wr_data_in;
      if (m_busy > 0) begin
        if (buf_swap_in) m_err = 1'b1;
        m_busy--;
        if (m_busy == 0 && m_clearing) begin
          m_clearing = 1'b0;
          chk_zero   = 1'b1;
          for (int i = 0; i < DEPTH; i++) begin
            ref_mem[0][i] = '0;
            ref_mem[1][i] = '0;
          end
        end
      end else if (buf_swap_in) begin
        m_front = !m_front;
        m_busy  = RD_LAT;
      end
    end
    #1;
  endtask

  task automatic rand_io(input int swap_pct, input int rst_pm);
    logic_rd_addr_in  = ADDR_W'($urandom);
    render_rd_addr_in = ADDR_W'($urandom);
    logic_wr_addr_in  = ADDR_W'($urandom);
    logic_wr_data_in  = DATA_W'($urandom);
    logic_wr_en_in    = 1'($urandom);
    buf_swap_in       = ($urandom_range(99) < swap_pct);
    rst_in            = ($urandom_range(999) < rst_pm);
  endtask

  // Counts cycles until ready is seen high (inclusive), bounded.
  task automatic wait_ready(output int n);
    n = 0;
    do begin
      cycle();
      n++;
      rand_io(0, 0);
      logic_wr_en_in = 1'b0;
    end while (!last_ready && n < 100);
  endtask

  int n;

  initial begin
    rst_in = 1'b1; buf_swap_in = 1'b0; logic_wr_en_in = 1'b0;
    logic_rd_addr_in = '0; logic_wr_addr_in = '0; render_rd_addr_in = '0;
    logic_wr_data_in = '0;

    // Reset long enough for the banks to fill with junk, then release.
    repeat (DEPTH + 2) cycle();
    scramble = 1'b0;
    cycle();
    rst_in = 1'b0;
    wait_ready(n);
    check("clear_len", 32'(n), 32'(DEPTH + 1));

    // Write 0xBEEF to the back bank; front still reads 0.
    logic_wr_en_in = 1'b1; logic_wr_addr_in = 5; logic_wr_data_in = 16'hBEEF;
    logic_rd_addr_in = 5;
    cycle();
    logic_wr_en_in = 1'b0;
    repeat (RD_LAT) cycle();
    check("pre_swap_rd", 32'(last_logic), 32'd0);

    // Swap timing: ready low in swap cycle plus RD_LAT more.
    buf_swap_in = 1'b1;
    cycle();
    check("ready_swap_cycle", 32'(last_ready), 32'd0);
    buf_swap_in = 1'b0;
    wait_ready(n);
    check("settle_len", 32'(n), 32'(RD_LAT + 1));
    logic_rd_addr_in = 5;
    cycle();
    logic_rd_addr_in = 0;
    repeat (RD_LAT) cycle();
    check("beef_after_swap", 32'(last_logic), 32'hBEEF);

    // Back-to-back swap: second is dropped, error sticks.
    check("err_clean", 32'(last_err), 32'd0);
    buf_swap_in = 1'b1;
    cycle();
    cycle();
    buf_swap_in = 1'b0;
    cycle();
    check("err_set", 32'(last_err), 32'd1);
    wait_ready(n);
    repeat (5) cycle();
    check("err_sticky", 32'(last_err), 32'd1);

    // Render read issued the cycle before a swap returns old-front data.
    logic_wr_en_in = 1'b1; logic_wr_addr_in = 3; logic_wr_data_in = 16'hA5A5;
    cycle();
    logic_wr_en_in = 1'b0;
    render_rd_addr_in = 3;
    cycle();
    render_rd_addr_in = 0;
    buf_swap_in = 1'b1;
    cycle();
    buf_swap_in = 1'b0;
    repeat (RD_LAT - 1) cycle();
    check("render_old_front", 32'(last_render), 32'd0);
    render_rd_addr_in = 3;
    cycle();
    render_rd_addr_in = 0;
    repeat (RD_LAT) cycle();
    check("render_new_front", 32'(last_render), 32'hA5A5);

    // Reset in the middle of clearing (while address 9 is being written).
    rst_in = 1'b1;
    cycle();
    rst_in = 1'b0;
    repeat (9) cycle();
    rst_in = 1'b1;
    cycle();
    rst_in = 1'b0;
    wait_ready(n);
    check("clear_len_restart", 32'(n), 32'(DEPTH + 1));
    check("err_after_reset", 32'(last_err), 32'd0);

    // Random traffic with occasional swaps and rare resets.
    for (int i = 0; i < 1500; i++) begin
      rand_io(15, 4);
      cycle();
    end
    rst_in = 1'b0;
    buf_swap_in = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
